fu_issue_arbiter: RTL and testbench

FU_ISSUE_ARBITER -- requirements
Module: fu_issue_arbiter

---
 rtl/fu_issue_arbiter.sv | 114 +++++++++++
 tb/tb_fu_issue_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fu_issue_arbiter.sv
// Issue arbiter: picks one ready reservation-station entry per transfer and presents it to the FU.
// Build option FU_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority (lowest index wins).
module fu_issue_arbiter #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 flush,
    input  logic                 fu_ready,
    output logic                 grant_valid,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic [CNT_W-1:0]     xfer_count
);
    localparam int IW = $clog2(N);

    // state | meaning
    // IDLE  | no grant presented, waiting for any request
    // GRANT | grant held until the FU accepts it or a flush drops it
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             xfer;
    logic             found;
    logic [N-1:0]     cand;
    logic [IW-1:0]    base;
    logic [IW-1:0]    scan_idx;
    logic [IW-1:0]    win_idx;

    assign xfer = (state_q == ST_GRANT) && fu_ready && !flush;
    // The entry just transferred is not eligible for the back-to-back pick.
    assign cand = (state_q == ST_GRANT) ? (req & ~grant_q) : req;

`ifdef FU_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q, ptr_d;

    // Back-to-back picks already search from the post-transfer pointer.
    assign ptr_d = xfer ? (idx_q + IW'(1)) : ptr_q;
    assign base  = ptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign base = '0;
`endif

    // N is a power of two, so base+k wraps naturally at IW bits.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = base + IW'(k);
            if (!found && cand[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        cnt_d   = xfer ? (cnt_q + CNT_W'(1)) : cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            grant_d = '0;
            idx_d   = '0;
        end else if ((state_q == ST_IDLE) || xfer) begin
            if (found) begin
                state_d = ST_GRANT;
                grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
                idx_d   = win_idx;
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_valid = (state_q == ST_GRANT);
    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign xfer_count  = cnt_q;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Bench for fu_issue_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_fu_issue_arbiter;
    localparam int N     = 8;
    localparam int CNT_W = 4;
`ifdef FU_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             flush;
    logic             fu_ready;
    logic             grant_valid;
    logic [N-1:0]     grant;
    logic [2:0]       grant_idx;
    logic [CNT_W-1:0] xfer_count;

    int total = 0;
    int bad   = 0;

    int m_gv  = 0;
    int m_idx = 0;
    int m_ptr = 0;
    int m_cnt = 0;

    fu_issue_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .flush       (flush),
        .fu_ready    (fu_ready),
        .grant_valid (grant_valid),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .xfer_count  (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lowest requesting index at or above base, else the lowest requesting index overall.
    function automatic int pick(input logic [N-1:0] c, input int base);
        int set_q[$];
        for (int i = 0; i < N; i++) if (c[i]) set_q.push_back(i);
        if (set_q.size() == 0) return -1;
        foreach (set_q[j]) if (set_q[j] >= base) return set_q[j];
        return set_q[0];
    endfunction

    task automatic model_edge();
        int w;
        int nptr;
        logic [N-1:0] c;
        if (!rst_n) begin
            m_gv = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
        end else if (flush) begin
            m_gv = 0; m_idx = 0;
        end else if (m_gv == 0) begin
            w = pick(req, RR ? m_ptr : 0);
            if (w >= 0) begin m_gv = 1; m_idx = w; end
        end else if (fu_ready) begin
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
            nptr  = (m_idx + 1) % N;
            c     = req;
            c[m_idx] = 1'b0;
            w = pick(c, RR ? nptr : 0);
            m_ptr = nptr;
            if (w >= 0) m_idx = w;
            else begin m_gv = 0; m_idx = 0; end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [N-1:0] exp_grant;
        @(posedge clk);
        model_edge();
        #1;
        exp_grant = (m_gv != 0) ? (N'(1) << m_idx) : '0;
        check("grant_valid", 32'(grant_valid), 32'(m_gv));
        check("grant",       32'(grant),       32'(exp_grant));
        check("grant_idx",   32'(grant_idx),   32'(m_idx));
        check("xfer_count",  32'(xfer_count),  32'(m_cnt));
    endtask

    task automatic drive(input logic r, input logic [N-1:0] q, input logic f,
                         input logic fr, input int n);
        rst_n = r; req = q; flush = f; fu_ready = fr;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 1'b0; req = '0; flush = 1'b0; fu_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2);
        check("reset_gv",  32'(grant_valid), 32'd0);
        check("reset_cnt", 32'(xfer_count),  32'd0);

        drive(1'b1, 8'h00, 1'b0, 1'b1, 5);
        drive(1'b1, 8'hFF, 1'b0, 1'b1, 10);
        drive(1'b1, 8'h00, 1'b0, 1'b1, 2);

        drive(1'b0, 8'h00, 1'b0, 1'b0, 1);
        drive(1'b1, 8'b0100_1010, 1'b0, 1'b0, 5);
        drive(1'b1, 8'b0100_1010, 1'b0, 1'b1, 3);
        drive(1'b1, 8'h00, 1'b0, 1'b1, 2);

        // Set the pointer to 5, grant 5, then flush it while the FU is ready.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1);
        drive(1'b1, 8'b0001_0000, 1'b0, 1'b1, 2);
        drive(1'b1, 8'h00, 1'b0, 1'b1, 1);
        drive(1'b1, 8'b0010_0000, 1'b0, 1'b0, 2);
        drive(1'b1, 8'b1000_0001, 1'b1, 1'b1, 1);
        drive(1'b1, 8'b1000_0001, 1'b0, 1'b0, 2);
        drive(1'b1, 8'b1000_0001, 1'b0, 1'b1, 6);

        // Counter wrap and reset during an outstanding grant.
        drive(1'b1, 8'hFF, 1'b0, 1'b1, 20);
        drive(1'b0, 8'hFF, 1'b0, 1'b1, 1);
        check("rst_mid_gv",  32'(grant_valid), 32'd0);
        check("rst_mid_cnt", 32'(xfer_count),  32'd0);
        check("rst_mid_idx", 32'(grant_idx),   32'd0);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 63) != 0),
                  N'($urandom),
                  ($urandom_range(0, 15) == 0),
                  1'($urandom),
                  1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
